// File: rtl/shift_engine_param.sv
// rtl/shift_engine_param.sv - parametrised shift register with counted shift sequencer
//
// Purpose:
//   WIDTH-bit register (index 0 .. WIDTH-1) with parallel load, single-step
//   shifting in IDLE and an autonomous N-step shift sequence with a one-cycle
//   completion pulse. Four fill modes, two directions.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   Par_In       parallel load data
//   Par_load     load Par_In (also aborts a running sequence)
//   Ser_In       serial fill bit for fill mode 00
//   shift_en     single-step shift, IDLE only
//   start        begin a counted sequence, IDLE only
//   shift_count  number of steps in the sequence
//   dir          0: i-1 -> i, fill at index 0; 1: i+1 -> i, fill at index WIDTH-1
//   mode         00 Ser_In, 01 rotate, 10 replicate entry-end bit, 11 zero
//   Par_out      register contents
//   Ser_Out      bit at the exit end for the effective direction
//   busy         high while the sequence is shifting
//   done         one-cycle completion pulse

module shift_engine_param #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [0:WIDTH-1]   Par_In,
  input  logic               Par_load,
  input  logic               Ser_In,
  input  logic               shift_en,
  input  logic               start,
  input  logic [CNT_W-1:0]   shift_count,
  input  logic               dir,
  input  logic [1:0]         mode,
  output logic [0:WIDTH-1]   Par_out,
  output logic               Ser_Out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [0:WIDTH-1]   data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dir_q;
  logic [1:0]         mode_q;

  logic               eff_dir;
  logic [1:0]         eff_mode;
  logic               exit_bit;
  logic               entry_bit;
  logic               fill_bit;
  logic [0:WIDTH-1]   stepped;
  logic               last_step;

  // Only IDLE follows the live direction/mode; once a sequence is latched the
  // inputs are free to change without disturbing it.
  assign eff_dir   = (state_q == ST_IDLE) ? dir  : dir_q;
  assign eff_mode  = (state_q == ST_IDLE) ? mode : mode_q;

  assign exit_bit  = eff_dir ? data_q[0] : data_q[WIDTH-1];
  assign entry_bit = eff_dir ? data_q[WIDTH-1] : data_q[0];

  always_comb begin
    fill_bit = 1'b0;
    case (eff_mode)
      2'b00:   fill_bit = Ser_In;
      2'b01:   fill_bit = exit_bit;
      2'b10:   fill_bit = entry_bit;
      default: fill_bit = 1'b0;
    endcase
  end

  // Leftmost concatenation element lands on index 0.
  always_comb begin
    stepped = data_q;
    if (!eff_dir) stepped = {fill_bit, data_q[0:WIDTH-2]};
    else          stepped = {data_q[1:WIDTH-1], fill_bit};
  end

  assign last_step = (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Par_load)                     state_d = ST_IDLE;
        else if (start && shift_count != '0) state_d = ST_SHIFT;
        else if (start)                   state_d = ST_DONE;
      end
      ST_SHIFT: begin
        if (Par_load)       state_d = ST_IDLE;
        else if (last_step) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  // Datapath: register, remaining count and latched sequence controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Par_load) begin
            data_q <= Par_In;
          end else if (start) begin
            if (shift_count != '0) begin
              cnt_q  <= shift_count;
              dir_q  <= dir;
              mode_q <= mode;
            end
          end else if (shift_en) begin
            data_q <= stepped;
          end
        end
        ST_SHIFT: begin
          if (Par_load) begin
            data_q <= Par_In;
            cnt_q  <= '0;
          end else begin
            data_q <= stepped;
            cnt_q  <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (Par_load) data_q <= Par_In;
        end
        default: ;
      endcase
    end
  end

  assign Par_out = data_q;
  assign Ser_Out = exit_bit;

endmodule
